// File: rtl/ibex_rvfi_trace_buffer.sv
// rtl/ibex_rvfi_trace_buffer.sv - RVFI retirement trace buffer with wrap, stop-full and PC-trigger capture
module ibex_rvfi_trace_buffer #(
  parameter int Depth = 16,
  parameter int CntW  = 16,
  localparam int PtrW = $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  input  logic [31:0]       trig_pc_i,
  input  logic [PtrW:0]     post_trig_i,
  input  logic              rvfi_valid_i,
  input  logic [31:0]       rvfi_pc_rdata_i,
  input  logic [31:0]       rvfi_insn_i,
  input  logic [4:0]        rvfi_rd_addr_i,
  input  logic [31:0]       rvfi_rd_wdata_i,
  input  logic              rvfi_trap_i,
  input  logic              rvfi_intr_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [31:0]       rd_pc_o,
  output logic [31:0]       rd_insn_o,
  output logic [4:0]        rd_rd_addr_o,
  output logic [31:0]       rd_rd_wdata_o,
  output logic [1:0]        rd_flags_o,
  output logic [PtrW:0]     count_o,
  output logic              triggered_o,
  output logic              frozen_o,
  output logic [CntW-1:0]   dropped_o
);

  localparam logic [PtrW:0] LP_DEPTH = (PtrW+1)'(Depth);
  localparam logic [PtrW:0] LP_ONE   = (PtrW+1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_POST, ST_FROZEN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_en_q;
  logic [1:0]        r_mode;
  logic [PtrW:0]     r_post_cnt;
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW:0]     r_count;
  logic              r_triggered;
  logic [CntW-1:0]   r_dropped;

  logic [31:0]       r_pc_mem    [Depth];
  logic [31:0]       r_insn_mem  [Depth];
  logic [4:0]        r_rd_mem    [Depth];
  logic [31:0]       r_wdata_mem [Depth];
  logic [1:0]        r_flags_mem [Depth];

  logic              w_arm;
  logic              w_capturing;
  logic              w_full;
  logic              w_pop;
  logic              w_try;
  logic              w_refuse;
  logic              w_push;
  logic              w_overwrite;
  logic              w_trig_hit;
  logic [PtrW:0]     w_post_clamp;

  assign w_arm        = enable_i & ~r_en_q & (r_state == ST_IDLE);
  assign w_capturing  = (r_state == ST_CAPTURE) | (r_state == ST_POST);
  assign w_full       = (r_count == LP_DEPTH);
  assign w_pop        = rd_ready_i & (r_count != '0);
  assign w_try        = rvfi_valid_i & w_capturing;
  // A pop in the same cycle frees a slot, so stop-full only refuses when nothing drains.
  assign w_refuse     = w_try & (r_mode == 2'd1) & w_full & ~w_pop;
  assign w_push       = w_try & ~w_refuse;
  assign w_overwrite  = w_push & w_full & ~w_pop;
  assign w_trig_hit   = (r_state == ST_CAPTURE) & (r_mode == 2'd2) & w_push &
                        (rvfi_pc_rdata_i == trig_pc_i);
  assign w_post_clamp = (post_trig_i > LP_DEPTH) ? LP_DEPTH : post_trig_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!enable_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arm) w_next = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (w_trig_hit) begin
            w_next = (w_post_clamp == '0) ? ST_FROZEN : ST_POST;
          end else if (w_refuse) begin
            w_next = ST_FROZEN;
          end
        end
        ST_POST: begin
          if (w_push && (r_post_cnt == LP_ONE)) w_next = ST_FROZEN;
        end
        ST_FROZEN: w_next = ST_FROZEN;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // r_en_q resets high so an enable held through reset must drop and re-rise to arm.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en_q      <= 1'b1;
      r_mode      <= 2'd0;
      r_post_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_triggered <= 1'b0;
      r_dropped   <= '0;
    end else begin
      r_en_q <= enable_i;
      if (w_arm) begin
        r_mode      <= (mode_i == 2'd3) ? 2'd0 : mode_i;
        r_post_cnt  <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_triggered <= 1'b0;
        r_dropped   <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop || w_overwrite) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop && !w_full) begin
          r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
          r_count <= r_count - 1'b1;
        end
        if ((w_refuse || w_overwrite) && (r_dropped != '1)) r_dropped <= r_dropped + 1'b1;
        if (w_trig_hit) begin
          r_triggered <= 1'b1;
          r_post_cnt  <= w_post_clamp;
        end else if ((r_state == ST_POST) && w_push) begin
          r_post_cnt  <= r_post_cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= rvfi_pc_rdata_i;
      r_insn_mem[r_wr_ptr]  <= rvfi_insn_i;
      r_rd_mem[r_wr_ptr]    <= rvfi_rd_addr_i;
      r_wdata_mem[r_wr_ptr] <= rvfi_rd_wdata_i;
      r_flags_mem[r_wr_ptr] <= {rvfi_trap_i, rvfi_intr_i};
    end
  end

  assign rd_valid_o    = (r_count != '0);
  assign rd_pc_o       = r_pc_mem[r_rd_ptr];
  assign rd_insn_o     = r_insn_mem[r_rd_ptr];
  assign rd_rd_addr_o  = r_rd_mem[r_rd_ptr];
  assign rd_rd_wdata_o = r_wdata_mem[r_rd_ptr];
  assign rd_flags_o    = r_flags_mem[r_rd_ptr];
  assign count_o       = r_count;
  assign triggered_o   = r_triggered;
  assign frozen_o      = (r_state == ST_FROZEN);
  assign dropped_o     = r_dropped;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// tb/tb_ibex_rvfi_trace_buffer.sv - scoreboard bench for ibex_rvfi_trace_buffer
module tb_ibex_rvfi_trace_buffer;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_i;
  logic        enable_i;
  logic [1:0]  mode_i;
  logic [31:0] trig_pc_i;
  logic [4:0]  post_trig_i;
  logic        rvfi_valid_i;
  logic [31:0] rvfi_pc_rdata_i;
  logic [31:0] rvfi_insn_i;
  logic [4:0]  rvfi_rd_addr_i;
  logic [31:0] rvfi_rd_wdata_i;
  logic        rvfi_trap_i;
  logic        rvfi_intr_i;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [31:0] rd_pc_o;
  logic [31:0] rd_insn_o;
  logic [4:0]  rd_rd_addr_o;
  logic [31:0] rd_rd_wdata_o;
  logic [1:0]  rd_flags_o;
  logic [4:0]  count_o;
  logic        triggered_o;
  logic        frozen_o;
  logic [15:0] dropped_o;

  ibex_rvfi_trace_buffer #(.Depth(DEPTH), .CntW(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .mode_i(mode_i),
    .trig_pc_i(trig_pc_i), .post_trig_i(post_trig_i),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
    .rvfi_insn_i(rvfi_insn_i), .rvfi_rd_addr_i(rvfi_rd_addr_i),
    .rvfi_rd_wdata_i(rvfi_rd_wdata_i), .rvfi_trap_i(rvfi_trap_i),
    .rvfi_intr_i(rvfi_intr_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_pc_o(rd_pc_o), .rd_insn_o(rd_insn_o), .rd_rd_addr_o(rd_rd_addr_o),
    .rd_rd_wdata_o(rd_rd_wdata_o), .rd_flags_o(rd_flags_o), .count_o(count_o),
    .triggered_o(triggered_o), .frozen_o(frozen_o), .dropped_o(dropped_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q[$];
  int          m_drop;
  logic        m_cap, m_trig, m_frozen, m_post;
  int          m_post_cnt;
  logic [1:0]  m_mode;
  int          n_popped;
  logic [31:0] last_pop;
  logic        mono_on, have_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return ~pc;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_A5A5;
  endfunction

  task automatic model_reset();
    q.delete();
    m_drop = 0; m_trig = 0; m_frozen = 0; m_post = 0; m_post_cnt = 0;
  endtask

  task automatic post_checks();
    chk("count", {27'd0, count_o}, q.size());
    chk("dropped", {16'd0, dropped_o}, m_drop);
    chk("triggered", {31'd0, triggered_o}, {31'd0, m_trig});
    chk("frozen", {31'd0, frozen_o}, {31'd0, m_frozen});
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy);
    logic [31:0] h;
    int          n;
    rvfi_valid_i    = v;
    rvfi_pc_rdata_i = pc;
    rvfi_insn_i     = insn_of(pc);
    rvfi_rd_addr_i  = pc[6:2];
    rvfi_rd_wdata_i = wdata_of(pc);
    rvfi_trap_i     = pc[3];
    rvfi_intr_i     = pc[2];
    rd_ready_i      = rdy;
    chk("rd_valid", {31'd0, rd_valid_o}, {31'd0, q.size() != 0});
    if (rdy && q.size() != 0) begin
      h = q.pop_front();
      chk("rd_pc", rd_pc_o, h);
      chk("rd_insn", rd_insn_o, insn_of(h));
      chk("rd_rd_addr", {27'd0, rd_rd_addr_o}, {27'd0, h[6:2]});
      chk("rd_wdata", rd_rd_wdata_o, wdata_of(h));
      chk("rd_flags", {30'd0, rd_flags_o}, {30'd0, h[3:2]});
      if (mono_on && have_prev) chk("monotonic", {31'd0, h > last_pop}, 32'd1);
      have_prev = 1'b1;
      last_pop  = h;
      n_popped++;
    end
    if (v && m_cap) begin
      if (m_mode == 2'd1 && q.size() == DEPTH) begin
        m_drop++; m_cap = 0; m_frozen = 1;
      end else begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          m_drop++;
        end
        q.push_back(pc);
        if (m_post) begin
          m_post_cnt--;
          if (m_post_cnt == 0) begin m_post = 0; m_cap = 0; m_frozen = 1; end
        end else if (m_mode == 2'd2 && pc == trig_pc_i) begin
          m_trig = 1;
          n = (int'(post_trig_i) > DEPTH) ? DEPTH : int'(post_trig_i);
          if (n == 0) begin m_cap = 0; m_frozen = 1; end
          else begin m_post = 1; m_post_cnt = n; end
        end
      end
    end
    @(posedge clk); #1;
    rvfi_valid_i = 1'b0;
    rd_ready_i   = 1'b0;
    post_checks();
  endtask

  task automatic arm(input logic [1:0] mode);
    enable_i = 1'b0;
    @(posedge clk); #1;
    enable_i = 1'b1;
    mode_i   = mode;
    @(posedge clk); #1;
    model_reset();
    m_cap  = 1;
    m_mode = (mode == 2'd3) ? 2'd0 : mode;
    post_checks();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; mode_i = 2'd0; trig_pc_i = 32'd0; post_trig_i = 5'd0;
    rvfi_valid_i = 1'b0; rvfi_pc_rdata_i = 32'd0; rvfi_insn_i = 32'd0; rvfi_rd_addr_i = 5'd0;
    rvfi_rd_wdata_i = 32'd0; rvfi_trap_i = 1'b0; rvfi_intr_i = 1'b0; rd_ready_i = 1'b0;
    mono_on = 1'b0; have_prev = 1'b0; n_popped = 0; last_pop = 32'd0;
    m_cap = 0; m_mode = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    post_checks();
    chk("reset_rd_valid", {31'd0, rd_valid_o}, 32'd0);
    rst_i = 1'b0;

    // mode 0: wrap, 20 pushes
    arm(2'd0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h1000 + 32'(i * 4), 1'b0);
    chk("wrap_count", {27'd0, count_o}, 32'd16);
    chk("wrap_dropped", {16'd0, dropped_o}, 32'd4);
    chk("wrap_head_pc", rd_pc_o, 32'h1010);
    drain();

    // mode 1: stop when full
    arm(2'd1);
    for (int i = 0; i < 17; i++) cyc(1'b1, 32'h2000 + 32'(i * 4), 1'b0);
    chk("stop_frozen", {31'd0, frozen_o}, 32'd1);
    chk("stop_count", {27'd0, count_o}, 32'd16);
    chk("stop_dropped", {16'd0, dropped_o}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h2100 + 32'(i * 4), 1'b0);
    drain();

    // mode 2: trigger at 0x80 with 3 post records
    trig_pc_i = 32'h80; post_trig_i = 5'd3;
    arm(2'd2);
    for (int i = 0; i <= 12; i++) begin
      cyc(1'b1, 32'h70 + 32'(i * 4), 1'b0);
      if (i == 4) chk("trig_at_80", {31'd0, triggered_o}, 32'd1);
      if (i == 7) chk("frozen_after_8c", {31'd0, frozen_o}, 32'd1);
    end
    drain();
    chk("trig_last_entry", last_pop, 32'h8C);

    // post count larger than Depth is clamped
    trig_pc_i = 32'h300; post_trig_i = 5'd31;
    arm(2'd2);
    for (int i = 0; i < 18; i++) cyc(1'b1, 32'h300 + 32'(i * 4), 1'b0);
    drain();

    // full with concurrent push and pop
    arm(2'd0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h5000 + 32'(i * 4), 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'h5100 + 32'(i * 4), 1'b1);
    chk("fullpp_count", {27'd0, count_o}, 32'd16);
    chk("fullpp_dropped", {16'd0, dropped_o}, 32'd0);
    drain();

    // reset while in POST
    trig_pc_i = 32'h200; post_trig_i = 5'd5;
    arm(2'd2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h1F8 + 32'(i * 4), 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    model_reset();
    m_cap = 0;
    chk("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("rst_count", {27'd0, count_o}, 32'd0);
    chk("rst_triggered", {31'd0, triggered_o}, 32'd0);
    chk("rst_frozen", {31'd0, frozen_o}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h400 + 32'(i * 4), 1'b0);

    // random back-pressure, 100 pushes
    arm(2'd0);
    n_popped = 0; mono_on = 1'b1; have_prev = 1'b0;
    for (int i = 0; i < 100; i++) cyc(1'b1, 32'h8000 + 32'(i * 4), 1'($urandom_range(0, 1)));
    chk("bp_conservation", 32'(n_popped) + {16'd0, dropped_o} + {27'd0, count_o}, 32'd100);
    drain();
    mono_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
